// File: rtl/imem_resp_ctrl_pkg.sv
// Shared fetch-side definitions: core widths, AHB-Lite encodings and the
// read-master state type.
package imem_resp_ctrl_pkg;

  localparam int CORE_ADDR_WIDTH  = 32;
  localparam int CORE_INSTR_WIDTH = 32;

  localparam logic [1:0] HTRANS_IDLE       = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ     = 2'b10;
  localparam logic [2:0] HSIZE_WORD        = 3'b010;
  localparam logic [2:0] HBURST_SINGLE     = 3'b000;
  localparam logic [3:0] HPROT_OPCODE_PRIV = 4'b0010;

  typedef enum logic [1:0] {
    AHB_IDLE = 2'b00,
    AHB_ADDR = 2'b01,
    AHB_DATA = 2'b10
  } ahb_state_e;

endpackage

// File: rtl/imem_resp_ctrl_if.sv
// AHB-Lite read-only bus between the instruction responder (master) and the
// system fabric (slave).
interface imem_resp_ctrl_if
  import imem_resp_ctrl_pkg::*;
#(
  parameter int AW = CORE_ADDR_WIDTH
);
  logic [AW-1:0]               HADDR;
  logic [1:0]                  HTRANS;
  logic [2:0]                  HSIZE;
  logic [2:0]                  HBURST;
  logic [3:0]                  HPROT;
  logic                        HWRITE;
  logic                        HREADY;
  logic                        HRESP;
  logic [CORE_INSTR_WIDTH-1:0] HRDATA;

  modport master (
    output HADDR, HTRANS, HSIZE, HBURST, HPROT, HWRITE,
    input  HREADY, HRESP, HRDATA
  );

  modport slave (
    input  HADDR, HTRANS, HSIZE, HBURST, HPROT, HWRITE,
    output HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/imem_resp_ctrl_ahb_rd.sv
// Single-beat AHB-Lite instruction read master with error capture.
//   state    | meaning
//   AHB_IDLE | no transfer; accepts start and latches the address
//   AHB_ADDR | address phase, NONSEQ driven, held while HREADY=0
//   AHB_DATA | data phase, completes on HREADY=1 (fill or fault)
module imem_resp_ctrl_ahb_rd
  import imem_resp_ctrl_pkg::*;
#(
  parameter int AW = CORE_ADDR_WIDTH
)(
  input  logic                        cpu_clk,
  input  logic                        cpu_rstn,
  input  logic                        start,
  input  logic [AW-1:0]               start_addr,
  input  logic [AW-1:0]               pc,
  input  logic                        imem_inv,
  imem_resp_ctrl_if.master            ahb,
  output logic                        busy,
  output logic                        fill_valid,
  output logic [AW-3:0]               fill_tag,
  output logic [CORE_INSTR_WIDTH-1:0] fill_data,
  output logic                        fault
);

  ahb_state_e    state_q, state_d;
  logic [AW-1:0] haddr_q, haddr_d;
  logic          flt_q, flt_d;
  logic [AW-1:0] flt_addr_q, flt_addr_d;
  logic [1:0]    htrans;

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q    <= AHB_IDLE;
      haddr_q    <= '0;
      flt_q      <= 1'b0;
      flt_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      haddr_q    <= haddr_d;
      flt_q      <= flt_d;
      flt_addr_q <= flt_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    haddr_d    = haddr_q;
    flt_d      = flt_q;
    flt_addr_d = flt_addr_q;
    fill_valid = 1'b0;
    htrans     = HTRANS_IDLE;

    // The fault belongs to one fetch address; moving away or invalidating drops it.
    if (flt_q && (imem_inv || (pc != flt_addr_q))) flt_d = 1'b0;

    unique case (state_q)
      AHB_IDLE: begin
        if (start) begin
          haddr_d = start_addr;
          state_d = AHB_ADDR;
        end
      end
      AHB_ADDR: begin
        htrans = HTRANS_NONSEQ;
        if (ahb.HREADY) state_d = AHB_DATA;
      end
      AHB_DATA: begin
        if (ahb.HREADY) begin
          state_d = AHB_IDLE;
          if (ahb.HRESP) begin
            flt_d      = 1'b1;
            flt_addr_d = haddr_q;
          end else begin
            fill_valid = 1'b1;
          end
        end
      end
      default: state_d = AHB_IDLE;
    endcase
  end

  assign ahb.HADDR  = haddr_q;
  assign ahb.HTRANS = htrans;
  assign ahb.HSIZE  = HSIZE_WORD;
  assign ahb.HBURST = HBURST_SINGLE;
  assign ahb.HPROT  = HPROT_OPCODE_PRIV;
  assign ahb.HWRITE = 1'b0;

  assign busy      = (state_q != AHB_IDLE);
  assign fill_tag  = haddr_q[AW-1:2];
  assign fill_data = ahb.HRDATA;
  assign fault     = flt_q && (pc == flt_addr_q);

endmodule

// File: rtl/imem_resp_ctrl.sv
// Instruction responder: 2-entry buffer indexed by addr[2], fed by ITCM reads
// (with pc+4 prefetch) or single-beat AHB reads for addresses outside ITCM.
module imem_resp_ctrl
  import imem_resp_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = CORE_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] ITCM_BASE  = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] ITCM_SIZE  = 32'h0001_0000,
  parameter int                    ITCM_AW    = 14
)(
  input  logic                        cpu_clk,
  input  logic                        cpu_rstn,
  input  logic [ADDR_WIDTH-1:0]       pc,
  output logic                        instr_read_data_valid,
  output logic [CORE_INSTR_WIDTH-1:0] instr_read_data,
  input  logic                        imem_inv,
  output logic                        instr_access_fault,
  output logic                        itcm_ren,
  output logic [ITCM_AW-1:0]          itcm_addr,
  input  logic [CORE_INSTR_WIDTH-1:0] itcm_rdata,
  imem_resp_ctrl_if.master            ahb
);

  localparam int                    TW        = ADDR_WIDTH - 2;
  localparam logic [ADDR_WIDTH-1:0] ITCM_MASK = ~(ITCM_SIZE - 1'b1);

  typedef struct packed {
    logic                        v;
    logic [TW-1:0]               tag;
    logic [CORE_INSTR_WIDTH-1:0] data;
  } ent_t;

  function automatic logic word_in_itcm(input logic [TW-1:0] w);
    logic [ADDR_WIDTH-1:0] a;
    a = {w, 2'b00};
    return (a & ITCM_MASK) == ITCM_BASE;
  endfunction

  ent_t [1:0]    ent_q, ent_d;
  logic          pend_q, pend_d;
  logic [TW-1:0] pend_tag_q, pend_tag_d;
  logic          run_q, run_d;

  logic                        aligned, hit_buf, hit_byp, hit, req_have, itcm_req, ahb_start;
  logic [TW-1:0]               pc_word, req_word;
  logic                        ahb_busy, ahb_fill, ahb_fault;
  logic [TW-1:0]               ahb_fill_tag;
  logic [CORE_INSTR_WIDTH-1:0] ahb_fill_data;

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      ent_q      <= '0;
      pend_q     <= 1'b0;
      pend_tag_q <= '0;
      run_q      <= 1'b0;
    end else begin
      ent_q      <= ent_d;
      pend_q     <= pend_d;
      pend_tag_q <= pend_tag_d;
      run_q      <= run_d;
    end
  end

  always_comb begin
    run_d   = 1'b1;
    aligned = (pc[1:0] == 2'b00);
    pc_word = pc[ADDR_WIDTH-1:2];

    hit_buf = aligned && ent_q[pc_word[0]].v && (ent_q[pc_word[0]].tag == pc_word);
    // The ITCM word landing this cycle is forwarded so a redirect costs one bubble.
    hit_byp = aligned && pend_q && (pend_tag_q == pc_word);
    hit     = hit_buf || hit_byp;

    req_word = hit ? (pc_word + 1'b1) : pc_word;
    req_have = (ent_q[req_word[0]].v && (ent_q[req_word[0]].tag == req_word)) ||
               (pend_q && (pend_tag_q == req_word));

    itcm_req  = run_q && aligned && word_in_itcm(pc_word) && word_in_itcm(req_word) &&
                !req_have && !ahb_busy && !imem_inv;
    ahb_start = run_q && aligned && !word_in_itcm(pc_word) && !hit && !ahb_fault && !pend_q;

    itcm_ren  = itcm_req;
    itcm_addr = itcm_req ? req_word[ITCM_AW-1:0] : '0;

    instr_read_data_valid = hit;
    instr_read_data       = hit_buf ? ent_q[pc_word[0]].data :
                            hit_byp ? itcm_rdata : '0;
    instr_access_fault    = ahb_fault;

    ent_d      = ent_q;
    pend_d     = itcm_req;
    pend_tag_d = itcm_req ? req_word : pend_tag_q;

    if (imem_inv) begin
      ent_d[0].v = 1'b0;
      ent_d[1].v = 1'b0;
    end else begin
      if (pend_q) begin
        ent_d[pend_tag_q[0]].v    = 1'b1;
        ent_d[pend_tag_q[0]].tag  = pend_tag_q;
        ent_d[pend_tag_q[0]].data = itcm_rdata;
      end
      if (ahb_fill) begin
        ent_d[ahb_fill_tag[0]].v    = 1'b1;
        ent_d[ahb_fill_tag[0]].tag  = ahb_fill_tag;
        ent_d[ahb_fill_tag[0]].data = ahb_fill_data;
      end
    end
  end

  imem_resp_ctrl_ahb_rd #(.AW(ADDR_WIDTH)) u_ahb_rd (
    .cpu_clk    (cpu_clk),
    .cpu_rstn   (cpu_rstn),
    .start      (ahb_start),
    .start_addr (pc),
    .pc         (pc),
    .imem_inv   (imem_inv),
    .ahb        (ahb),
    .busy       (ahb_busy),
    .fill_valid (ahb_fill),
    .fill_tag   (ahb_fill_tag),
    .fill_data  (ahb_fill_data),
    .fault      (ahb_fault)
  );

endmodule
